instruction_decoder: RTL and testbench

//   Control decoder of the Tiny-CPU datapath. Maps a 4-bit opcode onto register

---
 rtl/instruction_decoder.sv | 82 ++++++++
 tb/tb_instruction_decoder.sv | 136 +++++++++++++
 2 files changed

// File: rtl/instruction_decoder.sv
// rtl/instruction_decoder.sv - Tiny-CPU control decoder: opcode to register strobes and ALU select
module instruction_decoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    input  logic [3:0] instruction,
    output logic       Clear,
    output logic       EnableA,
    output logic       EnableB,
    output logic       EnableOut,
    output logic       S0,
    output logic       S1,
    output logic       S2,
    output logic       S3,
    output logic       illegal
);

    logic       clear_d;
    logic       enable_a_d;
    logic       enable_b_d;
    logic       enable_out_d;
    logic       illegal_d;
    logic [3:0] sel_d;
    logic [3:0] sel_q;

    always_comb begin
        clear_d      = 1'b0;
        enable_a_d   = 1'b0;
        enable_b_d   = 1'b0;
        enable_out_d = 1'b0;
        illegal_d    = 1'b0;
        sel_d        = 4'd0;
        // Unknown opcode bits match no item and fall to default, so X/Z decodes as illegal.
        case (instruction)
            4'd0:  ;
            4'd1:  clear_d    = 1'b1;
            4'd2:  enable_a_d = 1'b1;
            4'd3:  enable_b_d = 1'b1;
            4'd4:  begin enable_out_d = 1'b1; sel_d = 4'd1; end
            4'd5:  begin enable_out_d = 1'b1; sel_d = 4'd2; end
            4'd6:  begin enable_out_d = 1'b1; sel_d = 4'd3; end
            4'd7:  begin enable_out_d = 1'b1; sel_d = 4'd4; end
            4'd8:  begin enable_out_d = 1'b1; sel_d = 4'd5; end
            4'd9:  begin enable_out_d = 1'b1; sel_d = 4'd6; end
            4'd10: begin enable_out_d = 1'b1; sel_d = 4'd7; end
            4'd11: begin enable_out_d = 1'b1; sel_d = 4'd8; end
            4'd12: begin enable_out_d = 1'b1; sel_d = 4'd9; end
            default: illegal_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Clear     <= 1'b0;
            EnableA   <= 1'b0;
            EnableB   <= 1'b0;
            EnableOut <= 1'b0;
            illegal   <= 1'b0;
            sel_q     <= 4'd0;
        end else if (instr_valid) begin
            Clear     <= clear_d;
            EnableA   <= enable_a_d;
            EnableB   <= enable_b_d;
            EnableOut <= enable_out_d;
            illegal   <= illegal_d;
            sel_q     <= sel_d;
        end else begin
            // Idle cycle: strobes drop, ALU select keeps the last function.
            Clear     <= 1'b0;
            EnableA   <= 1'b0;
            EnableB   <= 1'b0;
            EnableOut <= 1'b0;
            illegal   <= 1'b0;
        end
    end

    assign S0 = sel_q[0];
    assign S1 = sel_q[1];
    assign S2 = sel_q[2];
    assign S3 = sel_q[3];

endmodule

// File: tb/tb_instruction_decoder.sv
// tb/tb_instruction_decoder.sv - directed self-checking bench for instruction_decoder
module tb_instruction_decoder;

    logic       clk;
    logic       rst_n;
    logic       instr_valid;
    logic [3:0] instruction;
    logic       Clear;
    logic       EnableA;
    logic       EnableB;
    logic       EnableOut;
    logic       S0;
    logic       S1;
    logic       S2;
    logic       S3;
    logic       illegal;

    int n_checks = 0;
    int n_fails  = 0;

    // Expected {Clear,EnableA,EnableB,EnableOut,S3,S2,S1,S0,illegal} for opcodes 0..12.
    logic [8:0] exp_tbl [0:12];

    instruction_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr_valid(instr_valid),
        .instruction(instruction),
        .Clear      (Clear),
        .EnableA    (EnableA),
        .EnableB    (EnableB),
        .EnableOut  (EnableOut),
        .S0         (S0),
        .S1         (S1),
        .S2         (S2),
        .S3         (S3),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] expected);
        logic [8:0] observed;
        int         strobes;
        observed = {Clear, EnableA, EnableB, EnableOut, S3, S2, S1, S0, illegal};
        n_checks++;
        assert (observed === expected) else begin
            n_fails++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
        strobes = $countones({Clear, EnableA, EnableB, EnableOut});
        n_checks++;
        assert (strobes <= 1) else begin
            n_fails++;
            $error("FAIL onehot_%s observed=%0d strobes expected<=1", tag, strobes);
        end
    endtask

    task automatic apply(input logic v, input logic [3:0] op, input logic [8:0] expected,
                         input string tag);
        @(negedge clk);
        instr_valid = v;
        instruction = op;
        @(posedge clk);
        #1;
        check(tag, expected);
    endtask

    initial begin
        exp_tbl[0]  = 9'b0000_0000_0;
        exp_tbl[1]  = 9'b1000_0000_0;
        exp_tbl[2]  = 9'b0100_0000_0;
        exp_tbl[3]  = 9'b0010_0000_0;
        exp_tbl[4]  = 9'b0001_0001_0;
        exp_tbl[5]  = 9'b0001_0010_0;
        exp_tbl[6]  = 9'b0001_0011_0;
        exp_tbl[7]  = 9'b0001_0100_0;
        exp_tbl[8]  = 9'b0001_0101_0;
        exp_tbl[9]  = 9'b0001_0110_0;
        exp_tbl[10] = 9'b0001_0111_0;
        exp_tbl[11] = 9'b0001_1000_0;
        exp_tbl[12] = 9'b0001_1001_0;

        rst_n       = 1'b0;
        instr_valid = 1'b1;
        instruction = 4'd4;
        #2;
        check("reset_no_clk", 9'b0);
        @(posedge clk);
        #1;
        check("reset_held_edge", 9'b0);

        @(negedge clk);
        rst_n = 1'b1;

        for (int op = 0; op <= 12; op++)
            apply(1'b1, 4'(op), exp_tbl[op], $sformatf("sweep_op%0d", op));

        apply(1'b1, 4'd14, 9'b0000_0000_1, "illegal_14");
        apply(1'b1, 4'd3,  9'b0010_0000_0, "ldb_after_illegal");
        apply(1'b1, 4'd13, 9'b0000_0000_1, "illegal_13");
        apply(1'b1, 4'd15, 9'b0000_0000_1, "illegal_15");
        apply(1'b0, 4'd4,  9'b0000_0000_0, "idle_after_illegal");

        apply(1'b1, 4'd8,  9'b0001_0101_0, "xor");
        apply(1'b0, 4'd8,  9'b0000_0101_0, "idle_holds_sel");
        apply(1'b0, 4'd2,  9'b0000_0101_0, "idle_holds_sel_2");
        apply(1'b1, 4'd11, 9'b0001_1000_0, "shr");

        apply(1'b1, 4'd1,  9'b1000_0000_0, "clr_b2b");
        apply(1'b1, 4'd2,  9'b0100_0000_0, "lda_b2b");
        apply(1'b1, 4'd2,  9'b0100_0000_0, "lda_repeat");
        apply(1'b1, 4'd0,  9'b0000_0000_0, "nop_after_lda");

        apply(1'b1, 4'd4,  9'b0001_0001_0, "add_stream_1");
        apply(1'b1, 4'd4,  9'b0001_0001_0, "add_stream_2");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_mid", 9'b0);
        @(posedge clk);
        #1;
        check("reset_mid_edge", 9'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("add_after_reset", 9'b0001_0001_0);
        apply(1'b1, 4'd9,  9'b0001_0110_0, "not_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
